// File: rtl/axis_osc_acq_controller_if.sv
// Observe-only AXI-Stream sample bus (no tready), shared by the capture core and the acquisition controller.
interface axis_osc_acq_controller_if #(
  parameter int unsigned SMPL_WIDTH = 16
) ();
  logic [SMPL_WIDTH-1:0] tdata;
  logic                  tvalid;

  modport master (output tdata, output tvalid);
  modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/axis_osc_acq_controller.sv
// Arms the oscilloscope capture core, triggers it on level crossings, counts captures and applies holdoff.
// Optional auto trigger on timeout when OSC_AUTO_TRG_EN is defined (adds port cfg_auto_tmo).
module axis_osc_acq_controller #(
  parameter int unsigned SMPL_WIDTH = 16,
  parameter int unsigned CNTR_WIDTH = 12,
  parameter int unsigned HOLD_WIDTH = 16,
  parameter int unsigned ACQ_WIDTH  = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    cfg_mode,
  input  logic                    cfg_edge,
  input  logic [SMPL_WIDTH-1:0]   cfg_level,
  input  logic [HOLD_WIDTH-1:0]   cfg_holdoff,
  input  logic [ACQ_WIDTH-1:0]    cfg_count,
`ifdef OSC_AUTO_TRG_EN
  input  logic [HOLD_WIDTH-1:0]   cfg_auto_tmo,
`endif
  axis_osc_acq_controller_if.slave s_axis,
  input  logic [CNTR_WIDTH:0]     osc_sts_data,
  output logic                    osc_run_flag,
  output logic                    osc_trg_flag,
  output logic [CNTR_WIDTH-1:0]   trg_addr,
  output logic [ACQ_WIDTH-1:0]    acq_cnt,
  output logic                    busy,
  output logic                    irq
);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, HOLDOFF} state_t;

  state_t                  state;
  logic                    stop_pend;
  logic                    prev_vld;
  logic signed [SMPL_WIDTH-1:0] prev;
  logic                    run_d;
  logic [HOLD_WIDTH-1:0]   hold_cnt;

  logic signed [SMPL_WIDTH-1:0] sample_c;
  logic signed [SMPL_WIDTH-1:0] level_c;
  logic                    rise_c;
  logic                    fall_c;
  logic                    cross_c;
  logic                    done_c;
  logic                    last_c;
  logic                    auto_fire_c;
  logic [ACQ_WIDTH-1:0]    acq_next_c;
  logic [ACQ_WIDTH-1:0]    acq_tgt_c;

  // Crossing detect and capture-completion decode
  always_comb begin
    sample_c   = s_axis.tdata[SMPL_WIDTH-1:0];
    level_c    = cfg_level;
    rise_c     = prev_vld && (prev < level_c) && (sample_c >= level_c);
    fall_c     = prev_vld && (prev > level_c) && (sample_c <= level_c);
    cross_c    = (state == CAPTURE) && s_axis.tvalid && (cfg_edge ? fall_c : rise_c);
    done_c     = (state == CAPTURE) && run_d && !osc_sts_data[0];
    acq_next_c = (&acq_cnt) ? acq_cnt : acq_cnt + ACQ_WIDTH'(1);
    acq_tgt_c  = (cfg_count == '0) ? ACQ_WIDTH'(1) : cfg_count;
    last_c     = stop_pend || stop || (!cfg_mode && (acq_next_c >= acq_tgt_c));
  end

`ifdef OSC_AUTO_TRG_EN
  logic [HOLD_WIDTH-1:0] auto_cnt;

  assign auto_fire_c = (state == CAPTURE) && (cfg_auto_tmo != '0) &&
                       (auto_cnt == cfg_auto_tmo - HOLD_WIDTH'(1));

  // Cycles in CAPTURE since entry or since the last crossing / auto trigger
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      auto_cnt <= '0;
    end else if (state != CAPTURE || cross_c || auto_fire_c) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + HOLD_WIDTH'(1);
    end
  end
`else
  assign auto_fire_c = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state        <= IDLE;
      stop_pend    <= 1'b0;
      prev_vld     <= 1'b0;
      prev         <= '0;
      run_d        <= 1'b0;
      hold_cnt     <= '0;
      osc_run_flag <= 1'b0;
      osc_trg_flag <= 1'b0;
      trg_addr     <= '0;
      acq_cnt      <= '0;
      busy         <= 1'b0;
      irq          <= 1'b0;
    end else begin
      irq          <= 1'b0;
      osc_trg_flag <= 1'b0;
      run_d        <= osc_sts_data[0];
      if (state == CAPTURE && s_axis.tvalid) begin
        prev     <= sample_c;
        prev_vld <= 1'b1;
      end
      case (state)
        IDLE: begin
          stop_pend <= 1'b0;
          if (start && !stop) begin
            acq_cnt      <= '0;
            state        <= ARM;
            osc_run_flag <= 1'b1;
            busy         <= 1'b1;
          end
        end
        ARM: begin
          prev_vld <= 1'b0;
          if (stop) stop_pend <= 1'b1;
          if (osc_sts_data[0]) begin
            state        <= CAPTURE;
            osc_run_flag <= 1'b0;
          end
        end
        CAPTURE: begin
          if (done_c) begin
            trg_addr <= osc_sts_data[CNTR_WIDTH:1];
            acq_cnt  <= acq_next_c;
            irq      <= 1'b1;
            if (last_c) begin
              state     <= IDLE;
              busy      <= 1'b0;
              stop_pend <= 1'b0;
            end else begin
              state    <= HOLDOFF;
              hold_cnt <= cfg_holdoff;
            end
          end else begin
            if (stop) stop_pend <= 1'b1;
            // A pending stop forces the trigger so the core can finish its capture
            osc_trg_flag <= cross_c || auto_fire_c || stop_pend || stop;
          end
        end
        HOLDOFF: begin
          if (stop) begin
            state     <= IDLE;
            busy      <= 1'b0;
            stop_pend <= 1'b0;
          end else if (hold_cnt == '0) begin
            state        <= ARM;
            osc_run_flag <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - HOLD_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_osc_acq_controller.sv
// Self-checking bench for axis_osc_acq_controller: crossing triggers, N-shot, stop, start corner cases, auto trigger.
module tb_axis_osc_acq_controller;
  localparam int unsigned SW = 16;
  localparam int unsigned CW = 12;
  localparam int unsigned HW = 16;
  localparam int unsigned AW = 16;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          start, stop, cfg_mode, cfg_edge;
  logic [SW-1:0] cfg_level;
  logic [HW-1:0] cfg_holdoff;
  logic [AW-1:0] cfg_count;
`ifdef OSC_AUTO_TRG_EN
  logic [HW-1:0] cfg_auto_tmo;
`endif
  logic [CW:0]   sts, sts_man;
  logic          osc_run_flag, osc_trg_flag, busy, irq;
  logic [CW-1:0] trg_addr;
  logic [AW-1:0] acq_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: trigger addresses the core reports, in completion order
  logic [CW-1:0] sb_q [$];

  // Behavioural capture core
  logic          core_en   = 1'b0;
  logic          core_run  = 1'b0;
  logic [CW-1:0] core_addr = '0;
  logic [1:0]    core_ph   = '0;
  logic [3:0]    core_dly  = '0;

  axis_osc_acq_controller_if #(.SMPL_WIDTH(SW)) s_axis ();

  axis_osc_acq_controller #(
    .SMPL_WIDTH(SW), .CNTR_WIDTH(CW), .HOLD_WIDTH(HW), .ACQ_WIDTH(AW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop),
    .cfg_mode(cfg_mode), .cfg_edge(cfg_edge), .cfg_level(cfg_level),
    .cfg_holdoff(cfg_holdoff), .cfg_count(cfg_count),
`ifdef OSC_AUTO_TRG_EN
    .cfg_auto_tmo(cfg_auto_tmo),
`endif
    .s_axis(s_axis.slave), .osc_sts_data(sts),
    .osc_run_flag(osc_run_flag), .osc_trg_flag(osc_trg_flag),
    .trg_addr(trg_addr), .acq_cnt(acq_cnt), .busy(busy), .irq(irq)
  );

  always #5 aclk = ~aclk;

  assign sts = core_en ? {core_addr, core_run} : sts_man;

  // Core: run request -> running after a delay; trigger -> finish 4 cycles later
  always @(posedge aclk) begin
    if (!core_en) begin
      core_run <= 1'b0;
      core_ph  <= 2'd0;
    end else begin
      case (core_ph)
        2'd0: if (osc_run_flag) begin core_dly <= 4'd2; core_ph <= 2'd1; end
        2'd1: if (core_dly == 0) begin core_run <= 1'b1; core_ph <= 2'd2; end
              else core_dly <= core_dly - 4'd1;
        2'd2: if (osc_trg_flag) begin core_dly <= 4'd4; core_ph <= 2'd3; end
        default: if (core_dly == 0) begin
                   core_run  <= 1'b0;
                   core_addr <= core_addr + CW'(7);
                   sb_q.push_back(core_addr + CW'(7));
                   core_ph   <= 2'd0;
                 end else core_dly <= core_dly - 4'd1;
      endcase
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({osc_run_flag, osc_trg_flag, busy, irq} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {osc_run_flag, osc_trg_flag, busy, irq});
    end
    n_checks++;
    if (trg_addr !== '0 || acq_cnt !== '0) begin
      n_fail++; $display("FAIL reset_regs: got addr %0d cnt %0d expected 0 0", trg_addr, acq_cnt);
    end
    aresetn = 1'b1;
    tick();
  endtask

  // Manual-core capture of one beat sequence, then completion with a given address
  task automatic test_rising();
    logic [SW-1:0] dat [5];
    logic          vld [5];
    logic          exp [5];
    dat = '{16'sd90, 16'sd95, 16'sd100, 16'sd105, 16'sd0};
    vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    core_en = 1'b0; sts_man = '0; cfg_mode = 1'b0; cfg_count = AW'(1);
    cfg_edge = 1'b0; cfg_level = 16'sd100; s_axis.tvalid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    sts_man = (CW+1)'(1); tick();
    for (int i = 0; i < 5; i++) begin
      s_axis.tdata = dat[i]; s_axis.tvalid = vld[i];
      tick();
      n_checks++;
      if (osc_trg_flag !== exp[i]) begin
        n_fail++; $display("FAIL rise_trg[%0d]: got %b expected %b", i, osc_trg_flag, exp[i]);
      end
    end
    s_axis.tvalid = 1'b0;
    sts_man = {12'h1A5, 1'b0}; sb_q.push_back(12'h1A5);
    tick();
    n_checks++;
    if (irq !== 1'b1 || busy !== 1'b0 || acq_cnt !== AW'(1) || trg_addr !== sb_q[0]) begin
      n_fail++; $display("FAIL rise_done: got irq %b busy %b cnt %0d addr %h expected 1 0 1 %h",
                         irq, busy, acq_cnt, trg_addr, sb_q[0]);
    end
    void'(sb_q.pop_front());
    tick();
  endtask

  task automatic test_falling();
    logic [SW-1:0] dat [6];
    logic          vld [6];
    logic          exp [6];
    dat = '{16'sd0, -16'sd100, -16'sd100, -16'sd60, 16'sd0, -16'sd70};
    vld = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    core_en = 1'b0; sts_man = '0; cfg_mode = 1'b0; cfg_count = AW'(0);
    cfg_edge = 1'b1; cfg_level = -16'sd50; s_axis.tvalid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    sts_man = (CW+1)'(1); tick();
    for (int i = 0; i < 6; i++) begin
      s_axis.tdata = dat[i]; s_axis.tvalid = vld[i];
      tick();
      n_checks++;
      if (osc_trg_flag !== exp[i]) begin
        n_fail++; $display("FAIL fall_trg[%0d]: got %b expected %b", i, osc_trg_flag, exp[i]);
      end
    end
    s_axis.tvalid = 1'b0;
    sts_man = {12'h2B6, 1'b0}; sb_q.push_back(12'h2B6);
    tick();
    n_checks++;
    if (irq !== 1'b1 || busy !== 1'b0 || trg_addr !== sb_q[0]) begin
      n_fail++; $display("FAIL fall_done: got irq %b busy %b addr %h expected 1 0 %h (count 0 acts as 1)",
                         irq, busy, trg_addr, sb_q[0]);
    end
    void'(sb_q.pop_front());
    tick();
  endtask

  task automatic test_nshot();
    int irqs = 0, min_gap = 1000, drop_cyc = -1, ramp = -200, cyc;
    logic prev_sts = 1'b0, prev_run = 1'b0;
    logic [CW-1:0] ea;
    cfg_mode = 1'b0; cfg_count = AW'(3); cfg_holdoff = HW'(10);
    cfg_edge = 1'b0; cfg_level = '0; core_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (cyc = 0; cyc < 3000 && busy; cyc++) begin
      s_axis.tdata = SW'(ramp); s_axis.tvalid = 1'b1;
      ramp = (ramp >= 200) ? -200 : ramp + 25;
      tick();
      if (irq) begin
        irqs++;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL nshot_irq: got irq %0d with no capture finished, expected none", irqs);
        end else begin
          ea = sb_q.pop_front();
          if (trg_addr !== ea || acq_cnt !== AW'(irqs)) begin
            n_fail++; $display("FAIL nshot_irq: got addr %h cnt %0d expected %h %0d", trg_addr, acq_cnt, ea, irqs);
          end
        end
      end
      if (prev_sts && !sts[0]) drop_cyc = cyc;
      if (!prev_run && osc_run_flag && drop_cyc >= 0 && (cyc - drop_cyc) < min_gap) min_gap = cyc - drop_cyc;
      prev_sts = sts[0]; prev_run = osc_run_flag;
    end
    s_axis.tvalid = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL nshot_timeout: got busy %b after %0d cycles expected 0", busy, cyc);
    end
    n_checks++;
    if (irqs != 3 || acq_cnt !== AW'(3)) begin
      n_fail++; $display("FAIL nshot_count: got irqs %0d cnt %0d expected 3 3", irqs, acq_cnt);
    end
    n_checks++;
    if (min_gap < 10 || min_gap == 1000) begin
      n_fail++; $display("FAIL nshot_holdoff: got gap %0d expected >= 10", min_gap);
    end
    core_en = 1'b0;
    tick();
  endtask

  task automatic test_stop_continuous();
    int low = 0, k;
    logic [CW-1:0] ea;
    cfg_mode = 1'b1; cfg_holdoff = HW'(4); cfg_edge = 1'b0; cfg_level = 16'sd100;
    s_axis.tdata = '0; s_axis.tvalid = 1'b1; core_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (k = 0; k < 50 && !(sts[0] && !osc_run_flag); k++) tick();
    n_checks++;
    if (k >= 50) begin
      n_fail++; $display("FAIL stop_arm_timeout: got no capture entry expected entry within 50");
    end
    stop = 1'b1; tick(); stop = 1'b0;
    if (!osc_trg_flag) low++;
    for (k = 0; k < 50 && !irq; k++) begin
      tick();
      if (!irq && !osc_trg_flag) low++;
    end
    n_checks++;
    if (low != 0 || !irq) begin
      n_fail++; $display("FAIL stop_trg_hold: got %0d low cycles irq %b expected 0 1", low, irq);
    end
    n_checks++;
    ea = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    if (trg_addr !== ea || acq_cnt !== AW'(1) || busy !== 1'b0) begin
      n_fail++; $display("FAIL stop_done: got addr %h cnt %0d busy %b expected %h 1 0", trg_addr, acq_cnt, busy, ea);
    end
    low = 0;
    for (k = 0; k < 20; k++) begin
      tick();
      if (irq || busy || osc_run_flag) low++;
    end
    n_checks++;
    if (low != 0) begin
      n_fail++; $display("FAIL stop_idle: got %0d active cycles expected 0", low);
    end
    s_axis.tvalid = 1'b0; core_en = 1'b0;
    tick();
  endtask

  task automatic test_start_stop_same();
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0; tick();
    n_checks++;
    if (busy !== 1'b0 || osc_run_flag !== 1'b0) begin
      n_fail++; $display("FAIL start_stop_same: got busy %b run %b expected 0 0", busy, osc_run_flag);
    end
  endtask

  task automatic test_start_busy();
    core_en = 1'b0; sts_man = '0; cfg_mode = 1'b1; cfg_holdoff = HW'(5); s_axis.tvalid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    sts_man = (CW+1)'(1); tick();
    sts_man = {12'h5A5, 1'b0}; sb_q.push_back(12'h5A5);
    tick();
    n_checks++;
    if (irq !== 1'b1 || trg_addr !== sb_q[0] || acq_cnt !== AW'(1)) begin
      n_fail++; $display("FAIL busy_capture: got irq %b addr %h cnt %0d expected 1 %h 1", irq, trg_addr, acq_cnt, sb_q[0]);
    end
    void'(sb_q.pop_front());
    start = 1'b1; tick(); start = 1'b0;
    n_checks++;
    if (acq_cnt !== AW'(1) || busy !== 1'b1) begin
      n_fail++; $display("FAIL start_while_busy: got cnt %0d busy %b expected 1 1", acq_cnt, busy);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || acq_cnt !== AW'(1)) begin
      n_fail++; $display("FAIL holdoff_stop: got busy %b cnt %0d expected 0 1", busy, acq_cnt);
    end
    tick();
  endtask

`ifdef OSC_AUTO_TRG_EN
  task automatic test_auto_trigger();
    core_en = 1'b0; sts_man = '0; cfg_mode = 1'b0; cfg_count = AW'(1);
    cfg_edge = 1'b0; cfg_level = 16'sd100; cfg_auto_tmo = HW'(20);
    s_axis.tdata = '0; s_axis.tvalid = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    sts_man = (CW+1)'(1); tick();
    for (int k = 1; k <= 25; k++) begin
      tick();
      n_checks++;
      if (osc_trg_flag !== (k == 20)) begin
        n_fail++; $display("FAIL auto_trg[%0d]: got %b expected %b", k, osc_trg_flag, (k == 20));
      end
    end
    sts_man = {12'h3C3, 1'b0}; sb_q.push_back(12'h3C3);
    tick();
    n_checks++;
    if (irq !== 1'b1 || trg_addr !== sb_q[0]) begin
      n_fail++; $display("FAIL auto_done: got irq %b addr %h expected 1 %h", irq, trg_addr, sb_q[0]);
    end
    void'(sb_q.pop_front());
    cfg_auto_tmo = '0; s_axis.tvalid = 1'b0;
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    core_en = 1'b0; sts_man = '0; cfg_mode = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    sts_man = (CW+1)'(1); tick();
    aresetn = 1'b0; tick(); aresetn = 1'b1;
    n_checks++;
    if ({busy, osc_run_flag, osc_trg_flag, irq} !== 4'b0000 || acq_cnt !== '0 || trg_addr !== '0) begin
      n_fail++; $display("FAIL reset_mid: got flags %b cnt %0d addr %h expected 0000 0 0",
                         {busy, osc_run_flag, osc_trg_flag, irq}, acq_cnt, trg_addr);
    end
    sts_man = '0; tick();
  endtask

  initial begin
    start = 1'b0; stop = 1'b0; cfg_mode = 1'b0; cfg_edge = 1'b0;
    cfg_level = '0; cfg_holdoff = '0; cfg_count = '0; sts_man = '0;
    s_axis.tdata = '0; s_axis.tvalid = 1'b0;
`ifdef OSC_AUTO_TRG_EN
    cfg_auto_tmo = '0;
`endif
    test_reset();
    test_rising();
    test_falling();
    test_nshot();
    test_stop_continuous();
    test_start_stop_same();
    test_start_busy();
`ifdef OSC_AUTO_TRG_EN
    test_auto_trigger();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
